// File: rtl/pipe_interlock.sv
`default_nettype none
// ============================================================================
// Module      : pipe_interlock
// Description : Hazard interlock and forwarding controller. Tracks pending
//               register writes of the in-flight stages after ID in a small
//               scoreboard and derives IF/ID hold, ID/EX bubble, branch flush,
//               operand forwarding selects and stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_interlock #(
    parameter int STAGES    = 3,   // in-flight writer stages after ID (2..6)
    parameter int REG_AW    = 5,   // register address width
    parameter int FWD_EN    = 0,   // 0: stall on any RAW, 1: forward
    parameter int RF_BYPASS = 0,   // 1: WR stage never a hazard
    parameter int CNT_W     = 16   // performance counter width
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_reg_wr,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_is_load,
    input  logic              ex_br_taken,
    input  logic              cnt_clr,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_bubble,
    output logic              flush_ifid,
    output logic [2:0]        fwd_a_sel,
    output logic [2:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Entries 1..c_CHK_DEPTH can still be hazards; with a bypassing register
    // file the WR entry has already delivered its data.
    localparam int              c_CHK_DEPTH = STAGES - RF_BYPASS;
    localparam logic [STAGES:1] c_CHK_MASK  = STAGES'((2 ** c_CHK_DEPTH) - 1);

    // Scoreboard: bit/element k describes the instruction k stages past ID.
    logic [STAGES:1]             r_sb_v;
    logic [STAGES:1][REG_AW-1:0] r_sb_rw;
    // Only the EX entry's load flag is ever consulted (load-use is a
    // one-stage hazard), so the flag is not carried further down the pipe.
    logic                        r_sb1_ld;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [STAGES:1] w_match_rs;
    logic [STAGES:1] w_match_rt;
    logic [STAGES:1] w_chk_rs;
    logic [STAGES:1] w_chk_rt;
    logic            w_hz_rs;
    logic            w_hz_rt;
    logic [2:0]      w_sel_a;
    logic [2:0]      w_sel_b;
    logic            w_hz;
    logic            w_stall;
    logic            w_flush;
    logic            w_issue;

    // Per-entry address match; register 0 is hard-wired and never matches.
    for (genvar k = 1; k <= STAGES; k++) begin : g_match
        assign w_match_rs[k] = r_sb_v[k] && (r_sb_rw[k] != '0) && (r_sb_rw[k] == id_rs);
        assign w_match_rt[k] = r_sb_v[k] && (r_sb_rw[k] != '0) && (r_sb_rw[k] == id_rt);
    end

    assign w_chk_rs = w_match_rs & c_CHK_MASK;
    assign w_chk_rt = w_match_rt & c_CHK_MASK;

    if (FWD_EN != 0) begin : g_fwd
        // Forwarding covers everything except a load still in EX.
        assign w_hz_rs = id_use_rs && w_match_rs[1] && r_sb1_ld;
        assign w_hz_rt = id_use_rt && w_match_rt[1] && r_sb1_ld;

        // Youngest producer wins: scan oldest to youngest, last hit sticks.
        always_comb begin
            w_sel_a = 3'd0;
            w_sel_b = 3'd0;
            for (int k = STAGES; k >= 1; k--) begin
                if (id_use_rs && w_chk_rs[k]) w_sel_a = 3'(k);
                if (id_use_rt && w_chk_rt[k]) w_sel_b = 3'(k);
            end
        end
    end else begin : g_nofwd
        // Without forwarding any pending writer of a used source stalls.
        assign w_hz_rs = id_use_rs && (|w_chk_rs);
        assign w_hz_rt = id_use_rt && (|w_chk_rt);
        assign w_sel_a = 3'd0;
        assign w_sel_b = 3'd0;
    end

    assign w_hz    = id_valid && (w_hz_rs || w_hz_rt);
    assign w_flush = ex_br_taken;
    assign w_stall = w_hz && !ex_br_taken;
    assign w_issue = id_valid && id_reg_wr && !w_hz && !ex_br_taken;

    // While reset is held the pipeline is kept drained: bubble, no hold.
    assign if_stall   = rst_n && w_stall;
    assign id_stall   = rst_n && w_stall;
    assign flush_ifid = rst_n && w_flush;
    assign ex_bubble  = !rst_n || w_stall || w_flush;
    assign fwd_a_sel  = rst_n ? w_sel_a : 3'd0;
    assign fwd_b_sel  = rst_n ? w_sel_b : 3'd0;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    // Scoreboard shift on the pipeline edge; a new entry only for issued writers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb_v   <= '0;
            r_sb_rw  <= '0;
            r_sb1_ld <= 1'b0;
        end else begin
            for (int k = 2; k <= STAGES; k++) begin
                r_sb_v[k]  <= r_sb_v[k-1];
                r_sb_rw[k] <= r_sb_rw[k-1];
            end
            r_sb_v[1]  <= w_issue;
            r_sb_rw[1] <= w_issue ? id_rw : '0;
            r_sb1_ld   <= w_issue && id_is_load;
        end
    end

    // Saturating stall/flush event counters; clear wins over increment.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_interlock.md
# pipe_interlock

Parametrised hazard interlock and forwarding controller for the pipelined CPU. It replaces the fixed stall logic with a per-stage destination scoreboard. From that scoreboard it produces IF/ID hold, ID/EX bubble, branch flush and operand-forwarding selects. It sits beside the ID stage, takes decoded source and destination fields plus the EX branch-taken result, and updates on the same clock edge as the pipeline registers.

## Interface
- STAGES, 3: number of in-flight stages after ID that hold a pending register write (EX..WR); legal range 2..6.
- REG_AW, 5: register address width.
- FWD_EN, 0: 0 = stall on any RAW hazard; 1 = forward, stall only on load-use.
- RF_BYPASS, 0: 1 = register file returns same-cycle write data, so the WR stage (entry STAGES) is never a hazard.
- CNT_W, 16: width of the performance counters.
- clk  in  1  pipeline clock; all state updates on the falling edge (same edge as the pipeline registers).
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source register addresses.
- id_use_rs, id_use_rt  in  1  the instruction reads that source.
- id_reg_wr  in  1  the instruction writes a register.
- id_rw  in  REG_AW  destination register (already RegDst-selected).
- id_is_load  in  1  the instruction is lw.
- ex_br_taken  in  1  the branch in EX resolved taken this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- if_stall  out  1  hold PC and the IF/ID register.
- id_stall  out  1  hold ID (equal to if_stall).
- ex_bubble  out  1  load a NOP (all control bits 0) into ID/EX.
- flush_ifid  out  1  replace IF/ID with a NOP.
- fwd_a_sel, fwd_b_sel  out  3  0 = register file; k = result of scoreboard entry k (1 = EX/MEM output … STAGES).
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Scoreboard sb[1..STAGES], each entry {v, rw, ld}. Entry 1 is the instruction now in EX; entry STAGES is the instruction in WR.
- Each edge: sb[k+1] <= sb[k], and the oldest entry is dropped.
- sb[1] <= {1, id_rw, id_is_load} when issue = id_valid & id_reg_wr & ~hz & ~ex_br_taken. Otherwise sb[1] <= {0, 0, 0}.
- match(k, r) = sb[k].v & sb[k].rw != 0 & sb[k].rw == r. Register 0 never matches.
- Hazard rules, applied to each used source r:
  - FWD_EN=0: hz if match(k, r) for any k in 1..STAGES-RF_BYPASS.
  - FWD_EN=1: hz if match(1, r) & sb[1].ld (load-use).
  - FWD_EN=1 select: fwd_x_sel = smallest k with match(k, r), restricted to k ≤ STAGES-RF_BYPASS. The youngest producer wins. Otherwise 0.
  - FWD_EN=0: both selects are tied to 0.
- Only id_valid instructions generate hz.
- Priority: ex_br_taken beats hz.
  - Flush cycle: flush_ifid=1, ex_bubble=1, if_stall=id_stall=0.
  - Stall cycle: if_stall=id_stall=1, ex_bubble=1, flush_ifid=0.
  - Otherwise all four outputs are 0.
- Counters: stall_cnt increments on each edge where a stall cycle occurs. flush_cnt increments on each edge where a flush cycle occurs. Both saturate at all-ones. cnt_clr has priority over increment.

## Timing
- All outputs are combinational from the current sb and the ID/EX inputs, with zero-cycle latency. The scoreboard and counters update on the falling edge of clk.
- Producer to dependent stall length, with back-to-back issue:
  - FWD_EN=0: STAGES-RF_BYPASS cycles.
  - FWD_EN=1: load-use costs 1 cycle; ALU-to-ALU costs 0.
- Flush lasts exactly the cycle ex_br_taken is high. A stalled instruction in ID is discarded, not issued.
- Reset (rst_n low, asynchronous): all sb.v=0 and counters=0. During reset if_stall=id_stall=flush_ifid=0, ex_bubble=1 and fwd selects=0.
- Reset asserted mid-stall: the stall drops immediately. The first edge after release begins from an empty scoreboard.

## Test plan
- FWD_EN=0, RF_BYPASS=0: add r3,r1,r2 then sub r4,r3,r1 -> id_stall high 3 cycles, sub issues on the 4th, stall_cnt=3. Repeat with RF_BYPASS=1 -> 2 cycles, stall_cnt=2.
- FWD_EN=1: add r3; sub r5,r3,r3; or r6,r3,r0 -> no stall. Sub gets fwd_a_sel=fwd_b_sel=1; or gets fwd_a_sel=2, fwd_b_sel=0.
- FWD_EN=1: lw r5; add r6,r5,r1 -> exactly 1 stall cycle with ex_bubble=1, then add issues with fwd_a_sel=2.
- Writes to r0 (addi r0,r1,4), then a reader of r0 -> no stall, selects 0, in both modes.
- Hazard stall and ex_br_taken in the same cycle -> flush_ifid=1, ex_bubble=1, if_stall=0. flush_cnt +1, stall_cnt unchanged, and no entry enters sb[1].
- Drive 0xFFFF+2 stall cycles (CNT_W=16) -> stall_cnt holds 0xFFFF. Pulse cnt_clr -> 0. Assert rst_n=0 mid-stall -> if_stall=0 immediately and counters=0.
